// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK.
// Latency: INHIBIT_CYCLES + 1 cycles of line ownership, then paced by the device clock; done/error one cycle after completion.
// Backpressure: tx_ready high only in IDLE; tx_valid while busy is ignored. Optional retry: define PS2_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, FAIL
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic                   fail_now;
  logic [IW-1:0]          inh_cnt;
  logic [TW-1:0]          to_cnt;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   parity;
`ifdef PS2_TX_RETRY_EN
  logic                   retried;
`endif

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Bring the asynchronous pad lines into the clk domain; idle lines read as high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  // Failure condition: timeout has priority over any coincident edge; a high data line on edge 11 is a NACK.
  always_comb begin
    fail_now = 1'b0;
    if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
      if (to_cnt >= TO_LAST) begin
        fail_now = 1'b1;
      end else if (state == ACK && fall && data_s) begin
        fail_now = 1'b1;
      end
    end
  end

  // Transfer sequencer with registered line drivers and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (fail_now) begin
`ifdef PS2_TX_RETRY_EN
        if (!retried) begin
          // First failure: replay the same byte from a fresh inhibit phase.
          retried     <= 1'b1;
          state       <= INHIBIT;
          inh_cnt     <= '0;
          ps2_clk_oe  <= 1'b1;
          ps2_data_oe <= 1'b0;
        end else begin
          state       <= FAIL;
          error       <= 1'b1;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
        end
`else
        state       <= FAIL;
        error       <= 1'b1;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (tx_valid) begin
              shreg       <= tx_data;
              parity      <= ~^tx_data;
              tx_ready    <= 1'b0;
              busy        <= 1'b1;
              inh_cnt     <= '0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              state       <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retried     <= 1'b0;
`endif
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          REQ: begin
            // Release the clock with data held low (start bit) so the device begins clocking.
            ps2_clk_oe <= 1'b0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
          SHIFT: begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (fall) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt < 4'd8) begin
                ps2_data_oe <= ~shreg[bit_cnt[2:0]];
              end else if (bit_cnt == 4'd8) begin
                ps2_data_oe <= ~parity;
              end else begin
                ps2_data_oe <= 1'b0;
                state       <= ACK;
              end
            end
          end
          ACK: begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (fall) state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (clk_s && data_s) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE, FAIL: begin
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
